// File: rtl/wb_bram_burst.sv
// wb_bram_burst: Wishbone block-RAM slave with byte-lane writes, classic reads
// and linear incrementing-burst reads at one beat per cycle (address prefetch).
// Latency: write ack is combinational (0 cycles). Read data and ack arrive one
// cycle after the request. A burst then streams one word per cycle while req holds.
// Backpressure: dropping stb in a burst discards the prefetched word, and the
// resumed burst costs one wait cycle. A held classic read is acked every second cycle.
// Ports: i_clk/i_rst (async active-high); i_cyc, i_stb, i_we, i_sel, i_adr (byte
//   address), i_cti, i_bte, i_dat (write data); o_dat (registered read data),
//   o_ack, o_err, o_rty (tied 0).
// Optional feature: define WB_BRAM_RANGE_CHECK_EN to terminate requests to
//   addresses above the memory with err. Without it, upper bits alias and err is 0.
module wb_bram_burst #(
  parameter int MEM_ADR_WIDTH = 11,
  parameter int DATA_BYTES    = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cyc,
  input  logic                    i_stb,
  input  logic                    i_we,
  input  logic [DATA_BYTES-1:0]   i_sel,
  input  logic [31:0]             i_adr,
  input  logic [2:0]              i_cti,
  input  logic [1:0]              i_bte,
  input  logic [8*DATA_BYTES-1:0] i_dat,
  output logic [8*DATA_BYTES-1:0] o_dat,
  output logic                    o_ack,
  output logic                    o_err,
  output logic                    o_rty
);

  localparam int OFS   = $clog2(DATA_BYTES);
  localparam int DEPTH = 2**MEM_ADR_WIDTH;

  typedef logic [MEM_ADR_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_RD_ACK, S_BURST} state_t;

  logic [DATA_BYTES-1:0][7:0] r_mem [DEPTH];

  state_t                  r_state;
  word_t                   r_exp;   // word index whose data sits in r_dat during BURST
  logic                    r_err;   // pending beat terminates with err instead of ack
  logic [8*DATA_BYTES-1:0] r_dat;

  logic  w_req, w_oor, w_linear, w_hit, w_new, w_wr, w_top;
  word_t w_word, w_nxt;

  assign w_req    = i_cyc & i_stb;
  assign w_word   = i_adr[MEM_ADR_WIDTH+OFS-1:OFS];
  assign w_linear = (i_cti == 3'b010) && (i_bte == 2'b00);
  assign w_nxt    = r_exp + 1'b1;
  assign w_top    = &r_exp;

`ifdef WB_BRAM_RANGE_CHECK_EN
  assign w_oor = |i_adr[31:MEM_ADR_WIDTH+OFS];
  logic w_unused;
  assign w_unused = &{1'b0, i_adr[OFS-1:0]};
`else
  assign w_oor = 1'b0;
  logic w_unused;
  assign w_unused = &{1'b0, i_adr[OFS-1:0], i_adr[31:MEM_ADR_WIDTH+OFS]};
`endif

  // A streaming beat: the prefetched word matches what the master now asks for.
  // Anything else while in BURST (write, jump, stb gap) is served like IDLE.
  assign w_hit = (r_state == S_BURST) & w_req & ~i_we & (w_word == r_exp);
  // The RD_ACK cycle belongs to the classic read being acked, so no new request
  // is taken then. This gives the every-second-cycle throughput.
  assign w_new = w_req & ~i_rst & (r_state != S_RD_ACK) & ~w_hit;
  assign w_wr  = w_new & i_we & ~w_oor;

  assign o_ack = ~i_rst & (((r_state == S_RD_ACK) & ~r_err) | (w_hit & ~r_err) | w_wr);
  assign o_err = ~i_rst & (((r_state == S_RD_ACK) & r_err) | (w_hit & r_err) |
                           (w_new & i_we & w_oor));
  assign o_rty = 1'b0;
  assign o_dat = r_dat;

  // Memory contents are not reset.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (i_sel[i]) r_mem[w_word][i] <= i_dat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_exp   <= '0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else begin
      case (r_state)
        S_RD_ACK: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: begin
          if (w_hit) begin
            if (r_err || (i_cti == 3'b111)) begin
              r_state <= S_IDLE;
              r_err   <= 1'b0;
            end else begin
              r_exp <= w_nxt;
`ifdef WB_BRAM_RANGE_CHECK_EN
              // Stepping past the top word: the next beat errors and ends the burst.
              if (w_top) r_err <= 1'b1;
              else       r_dat <= r_mem[w_nxt];
`else
              r_dat <= r_mem[w_nxt];
`endif
            end
          end else if (w_new) begin
            if (i_we) begin
              // Write: ack already given combinationally; capture the pre-write word.
              r_state <= S_IDLE;
              r_err   <= 1'b0;
              if (!w_oor) r_dat <= r_mem[w_word];
            end else begin
              r_exp   <= w_word;
              r_err   <= w_oor;
              r_state <= (w_linear && !w_oor) ? S_BURST : S_RD_ACK;
              if (!w_oor) r_dat <= r_mem[w_word];
            end
          end else begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bram_burst.sv
module tb_wb_bram_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w, dat_r;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err, rty;

  always #5 clk = ~clk;

  wb_bram_burst #(.MEM_ADR_WIDTH(11), .DATA_BYTES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_cyc(cyc), .i_stb(stb), .i_we(we), .i_sel(sel),
    .i_adr(adr), .i_cti(cti), .i_bte(bte), .i_dat(dat_w),
    .o_dat(dat_r), .o_ack(ack), .o_err(err), .o_rty(rty)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every read ack pops the next expected word.
  always @(negedge clk) begin
    if (ack === 1'b1 && err === 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL ack_err_both: got ack=1 err=1 expected not both");
    end
    if (ack === 1'b1 && we === 1'b0 && cyc && stb) begin
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected_ack: got data %h expected no ack", dat_r);
      end else begin
        check("sb_rdata", dat_r, sb_q.pop_front());
      end
    end
  end

  task automatic idle();
    cyc = 0; stb = 0; we = 0; sel = 0; cti = 0; bte = 0;
  endtask

  // Returns at the negedge where ack or err is seen; lat counts waited cycles.
  task automatic wait_term(output int lat);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack === 1'b1 || err === 1'b1) break;
      lat++;
      @(posedge clk); #1;
    end
  endtask

  // Called at posedge+1; leaves at posedge+1 with the bus idle.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] c, input logic [1:0] b,
                      output int lat, output logic e);
    cyc = 1; stb = 1; we = w; adr = a; dat_w = d; sel = s; cti = c; bte = b;
    wait_term(lat);
    e = err;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    int lat;
    logic e;
    logic [3:0] pat;
    int nack;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic e;
    logic [3:0] pat;
    int nack;

    vt[0]  = '{1'b1, 32'h10, 32'hAABBCCDD, 4'hF, 3'b000, 2'b00, 32'h0,        0};
    vt[1]  = '{1'b1, 32'h10, 32'h11223344, 4'h5, 3'b000, 2'b00, 32'h0,        0};
    vt[2]  = '{1'b0, 32'h10, 32'h0,        4'hF, 3'b000, 2'b00, 32'hAA22CC44, 1};
    vt[3]  = '{1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00, 32'h0,        0};
    vt[4]  = '{1'b1, 32'h20, 32'h00000000, 4'h8, 3'b000, 2'b00, 32'h0,        0};
    vt[5]  = '{1'b0, 32'h20, 32'h0,        4'hF, 3'b111, 2'b00, 32'h00ADBEEF, 1};
    vt[6]  = '{1'b1, 32'h24, 32'h12345678, 4'hF, 3'b010, 2'b00, 32'h0,        0};
    vt[7]  = '{1'b1, 32'h24, 32'hFFFFFFFF, 4'h2, 3'b000, 2'b00, 32'h0,        0};
    vt[8]  = '{1'b0, 32'h24, 32'h0,        4'hF, 3'b010, 2'b01, 32'h1234FF78, 1};
    vt[9]  = '{1'b1, 32'h28, 32'hCAFEF00D, 4'hF, 3'b000, 2'b00, 32'h0,        0};
    vt[10] = '{1'b0, 32'h10, 32'h0,        4'hF, 3'b010, 2'b10, 32'hAA22CC44, 1};

    // Reset state with a read pending.
    rst = 1; idle(); adr = 0; dat_w = 0;
    repeat (2) @(posedge clk);
    #1; cyc = 1; stb = 1; adr = 32'h0;
    @(negedge clk);
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_dat", dat_r, 32'h0);
    check("rst_rty", {31'b0, rty}, 32'h0);
    @(posedge clk); #1; rst = 0; idle();
    @(posedge clk); #1;

    // Table-driven classic writes and reads.
    foreach (vt[i]) begin
      if (!vt[i].we) sb_q.push_back(vt[i].exp);
      xfer(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, vt[i].cti, vt[i].bte, lat, e);
      check($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      check($sformatf("vec%0d_err", i), {31'b0, e}, 32'h0);
    end

    // Non-linear bte with a held stb: classic, acked every second cycle.
    cyc = 1; stb = 1; we = 0; adr = 32'h24; cti = 3'b010; bte = 2'b11;
    sb_q.push_back(32'h1234FF78); sb_q.push_back(32'hCAFEF00D);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); pat[k] = ack;
      @(posedge clk); #1;
      if (pat[k]) adr = adr + 4;
    end
    idle();
    check("nonlin_ack_pattern", {28'b0, pat}, 32'hA);

    // Reset pulse mid-run, then classic read.
    @(posedge clk); #1; rst = 1; cyc = 1; stb = 1; adr = 32'h0;
    @(negedge clk);
    check("rstpulse_ack", {31'b0, ack}, 32'h0);
    check("rstpulse_dat", dat_r, 32'h0);
    @(posedge clk); #1; rst = 0; idle();
    sb_q.push_back(32'hAA22CC44);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 2'b00, lat, e);
    check("rstpulse_rd_lat", lat, 1);

    // Preload words 0..7 = index.
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, i * 4, i, 4'hF, 3'b000, 2'b00, lat, e);
      check("preload_lat", lat, 0);
    end

    // Eight-beat linear burst.
    for (int i = 0; i < 8; i++) sb_q.push_back(i);
    cyc = 1; stb = 1; we = 0; adr = 0; cti = 3'b010; bte = 2'b00;
    wait_term(lat);
    check("burst_first_lat", lat, 1);
    nack = (ack === 1'b1) ? 1 : 0;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1; adr = i * 4; cti = (i == 7) ? 3'b111 : 3'b010;
      @(negedge clk); if (ack === 1'b1) nack++;
    end
    check("burst_ack_count", nack, 8);
    @(posedge clk); #1; idle();
    @(negedge clk);
    check("burst_end_ack", {31'b0, ack}, 32'h0);
    // Back in IDLE: a new burst at word 8 must wait one cycle (no stale prefetch).
    @(posedge clk); #1;
    sb_q.push_back(32'h00ADBEEF);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, 3'b010, 2'b00, lat, e);
    check("post_burst_lat", lat, 1);

    // Reset on the third beat of a burst.
    sb_q.push_back(0); sb_q.push_back(1);
    cyc = 1; stb = 1; we = 0; adr = 0; cti = 3'b010; bte = 2'b00;
    wait_term(lat);
    check("rstburst_lat", lat, 1);
    @(posedge clk); #1; adr = 4;
    @(negedge clk);
    check("rstburst_beat2", {31'b0, ack}, 32'h1);
    @(posedge clk); #1; adr = 8; rst = 1;
    @(negedge clk);
    check("rstburst_beat3_ack", {31'b0, ack}, 32'h0);
    check("rstburst_dat", dat_r, 32'h0);
    @(posedge clk); #1; rst = 0; idle();
    sb_q.push_back(2);
    xfer(1'b0, 32'h8, 32'h0, 4'hF, 3'b000, 2'b00, lat, e);
    check("rstburst_rd_lat", lat, 1);

`ifndef WB_BRAM_RANGE_CHECK_EN
    // Burst from the top word with wrap, stall and resume.
    xfer(1'b1, 32'h1FFC, 32'h7FF07FF0, 4'hF, 3'b000, 2'b00, lat, e);
    sb_q.push_back(32'h7FF07FF0); sb_q.push_back(0);
    cyc = 1; stb = 1; we = 0; adr = 32'h1FFC; cti = 3'b010; bte = 2'b00;
    wait_term(lat);
    check("wrap_first_lat", lat, 1);
    @(posedge clk); #1; adr = 32'h2000;
    @(negedge clk); check("wrap_beat2_ack", {31'b0, ack}, 32'h1);
    @(posedge clk); #1; stb = 0;
    @(negedge clk); check("stall1_ack", {31'b0, ack}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk); check("stall2_ack", {31'b0, ack}, 32'h0);
    @(posedge clk); #1; stb = 1; adr = 32'h2004;
    sb_q.push_back(1); sb_q.push_back(2);
    @(negedge clk); check("resume_wait_ack", {31'b0, ack}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk); check("resume_beat_ack", {31'b0, ack}, 32'h1);
    @(posedge clk); #1; adr = 32'h2008; cti = 3'b111;
    @(negedge clk); check("resume_last_ack", {31'b0, ack}, 32'h1);
    @(posedge clk); #1; idle();

    // Aliasing: upper address bits ignored, err never raised.
    xfer(1'b1, 32'h2000, 32'h55, 4'hF, 3'b000, 2'b00, lat, e);
    check("alias_wr_lat", lat, 0);
    check("alias_wr_err", {31'b0, e}, 32'h0);
    sb_q.push_back(32'h55);
    xfer(1'b0, 32'h0, 32'h0, 4'hF, 3'b000, 2'b00, lat, e);
    check("alias_rd_lat", lat, 1);
`else
    // Out-of-range write errors in the same cycle and leaves word 0 untouched.
    xfer(1'b1, 32'h2000, 32'h55, 4'hF, 3'b000, 2'b00, lat, e);
    check("oor_wr_lat", lat, 0);
    check("oor_wr_err", {31'b0, e}, 32'h1);
    sb_q.push_back(0);
    xfer(1'b0, 32'h0, 32'h0, 4'hF, 3'b000, 2'b00, lat, e);
    check("oor_word0_lat", lat, 1);
    check("oor_word0_err", {31'b0, e}, 32'h0);
    xfer(1'b0, 32'h2000, 32'h0, 4'hF, 3'b000, 2'b00, lat, e);
    check("oor_rd_lat", lat, 1);
    check("oor_rd_err", {31'b0, e}, 32'h1);
    check("oor_rd_dat", dat_r, 32'h0);
`endif

    repeat (2) @(posedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
